// File: rtl/arb_pkg.sv
// Shared definitions for the burst-transfer front end of the round-robin
// arbiter: FSM state type, default sizing and the one-hot legality test.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int DEF_N         = 4;
  localparam int DEF_DW        = 8;
  localparam int DEF_BURST_LEN = 4;

  // True when exactly one bit of v is set (callers zero-extend to 32 bits).
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/onehot_to_idx.sv
// Converts a one-hot vector (the arbiter grant) to a binary index and flags
// whether the vector really is one-hot. idx is only meaningful when
// valid_onehot is high. Supports N in 2..32.
module onehot_to_idx
  import arb_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] idx,
  output logic                 valid_onehot
);

  localparam int IW = $clog2(N);

  // OR together the indices of set bits; exact for a genuine one-hot input.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    idx          = '0;
    valid_onehot = is_onehot(32'(onehot));
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) idx = idx | IW'(i);
    end
  end

endmodule

// File: rtl/arb_burst_xfer.sv
// arb_burst_xfer: drives a round-robin arbiter's request vector, locks onto
// the granted requester and moves exactly BURST_LEN beats from it onto one
// shared valid/ready sink. Requests are withheld while a burst is in flight
// and for one GAP cycle after it, so the arbiter rotates only between bursts.
// Data path is purely combinational from state/owner and the inputs.
//
// Optional build macro ARB_BURST_XFER_GNT_CHECK_EN adds a sticky gnt_err
// output flagging multi-hot grants, or any grant outside IDLE.
module arb_burst_xfer
  import arb_pkg::*;
#(
  parameter  int N         = DEF_N,
  parameter  int DW        = DEF_DW,
  parameter  int BURST_LEN = DEF_BURST_LEN,
  localparam int IW        = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    src_valid,
  input  logic [N*DW-1:0] src_data,
  output logic [N-1:0]    src_ready,
  output logic [N-1:0]    arb_req,
  input  logic [N-1:0]    arb_gnt,
  output logic            m_valid,
  output logic [DW-1:0]   m_data,
  input  logic            m_ready,
  output logic [IW-1:0]   m_src,
  output logic            m_last,
  output logic            busy
`ifdef ARB_BURST_XFER_GNT_CHECK_EN
  ,
  output logic            gnt_err
`endif
);

  localparam logic [7:0] LAST_CNT = 8'(BURST_LEN - 1);

  state_t        state;
  logic [IW-1:0] owner;
  logic [7:0]    beat_cnt;

  logic [IW-1:0] gnt_idx;
  logic          gnt_onehot;
  logic          gnt_ok;
  logic          beat_fire;

  onehot_to_idx #(.N(N)) u_gnt_idx (
    .onehot       (arb_gnt),
    .idx          (gnt_idx),
    .valid_onehot (gnt_onehot)
  );

  // A grant counts only if it is one-hot and its requester is still asking.
  assign gnt_ok    = gnt_onehot && |(arb_gnt & src_valid);
  assign beat_fire = m_valid && m_ready;
  assign m_src     = owner;
  assign busy      = (state != IDLE);

  // Request/handshake steering. arb_req is also gated by rst_n so that every
  // output is low for the whole time reset is held, not just after an edge.
  always_comb begin
    arb_req   = '0;
    src_ready = '0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_last    = 1'b0;
    if (rst_n && state == IDLE) arb_req = src_valid;
    if (state == XFER) begin
      m_last = (beat_cnt == LAST_CNT);
      for (int i = 0; i < N; i++) begin
        if (owner == IW'(i)) begin
          m_valid      = src_valid[i];
          m_data       = src_data[i*DW +: DW];
          src_ready[i] = m_ready;
        end
      end
    end
  end

  // Burst FSM: grant acceptance, beat counting, single-cycle GAP.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values regardless of statement order.
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_ok) begin
            owner    <= gnt_idx;
            beat_cnt <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (beat_fire) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (m_last) state <= GAP;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_BURST_XFER_GNT_CHECK_EN
  // Sticky grant-protocol error: multi-hot anywhere, or any grant while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_err <= 1'b0;
    end else if (((|arb_gnt) && !gnt_onehot) || ((state != IDLE) && (|arb_gnt))) begin
      gnt_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_arb_burst_xfer.sv
// Self-checking bench for arb_burst_xfer. A driver emulates requesters, the
// sink and a round-robin arbiter (optionally issuing illegal grants); a
// monitor keeps a transaction-level model (expected-beat queue per burst)
// and compares every DUT output each cycle just before the rising edge.
module tb_arb_burst_xfer;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BL = 4;
  localparam int MEM = 1024;

  typedef struct {
    int         idx;
    logic [7:0] data;
    bit         last;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    src_valid = '0;
  logic [N*DW-1:0] src_data = '0;
  logic [N-1:0]    src_ready;
  logic [N-1:0]    arb_req;
  logic [N-1:0]    arb_gnt = '0;
  logic            m_valid;
  logic [DW-1:0]   m_data;
  logic            m_ready = 1'b0;
  logic [1:0]      m_src;
  logic            m_last;
  logic            busy;
`ifdef ARB_BURST_XFER_GNT_CHECK_EN
  logic            gnt_err;
`endif

  arb_burst_xfer #(.N(N), .DW(DW), .BURST_LEN(BL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .arb_req   (arb_req),
    .arb_gnt   (arb_gnt),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .m_src     (m_src),
    .m_last    (m_last),
    .busy      (busy)
`ifdef ARB_BURST_XFER_GNT_CHECK_EN
    ,
    .gnt_err   (gnt_err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Stimulus data streams and reference model state.
  logic [7:0] data_mem [N][MEM];
  int         sent_cnt [N];
  beat_t      exp_q[$];
  int         cur_owner = -1;
  bit         in_gap = 1'b0;
  int         last_src = 0;
  bit         gnt_err_exp = 1'b0;

  // Driver knobs.
  logic [N-1:0] valid_mask = '1;
  int           p_valid = 100;
  int           p_ready = 100;
  int           p_rand_gnt = 0;
  bit           force_gnt_en = 1'b0;
  logic [N-1:0] force_gnt = '0;
  int           rr_ptr = N - 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus, applied on the falling edge.
  task automatic drive_cycle();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      src_valid[i] = valid_mask[i] && ($urandom_range(99) < p_valid);
      src_data[i*DW +: DW] = data_mem[i][sent_cnt[i] % MEM];
    end
    m_ready = ($urandom_range(99) < p_ready);
    #1;
    if (force_gnt_en) begin
      arb_gnt = force_gnt;
    end else if ($urandom_range(99) < p_rand_gnt) begin
      arb_gnt = N'($urandom_range(15));
    end else begin
      arb_gnt = '0;
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (rr_ptr + k) % N;
        if (arb_req[j]) begin
          arb_gnt = N'(1) << j;
          rr_ptr  = j;
          break;
        end
      end
    end
  endtask

  // Monitor + reference model, sampled 1 time unit before each rising edge.
  always @(negedge clk) begin
    bit    idle;
    beat_t b;
    #4;
    if (!rst_n) begin
      exp_q.delete();
      cur_owner   = -1;
      in_gap      = 1'b0;
      last_src    = 0;
      gnt_err_exp = 1'b0;
    end else begin
      idle = (cur_owner < 0) && !in_gap;
      check("arb_req", arb_req, idle ? src_valid : '0);
      check("busy", busy, !idle);
      check("m_src", m_src, last_src);
`ifdef ARB_BURST_XFER_GNT_CHECK_EN
      check("gnt_err", gnt_err, gnt_err_exp);
      if (($countones(arb_gnt) > 1) || (!idle && arb_gnt != '0)) gnt_err_exp = 1'b1;
`endif
      if (cur_owner >= 0) begin
        check("m_valid", m_valid, src_valid[cur_owner]);
        check("src_ready", src_ready, m_ready ? (32'd1 << cur_owner) : 32'd0);
        check("m_last", m_last, exp_q.size() == 1);
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            check("beat_underflow", 1, 0);
          end else begin
            b = exp_q.pop_front();
            check("m_data", m_data, b.data);
            sent_cnt[cur_owner]++;
            if (b.last) begin
              cur_owner = -1;
              in_gap    = 1'b1;
            end
          end
        end
      end else begin
        check("m_valid_off", m_valid, 0);
        check("src_ready_off", src_ready, 0);
        if (in_gap) begin
          in_gap = 1'b0;
        end else if ($countones(arb_gnt) == 1 && (arb_gnt & src_valid) != '0) begin
          for (int i = 0; i < N; i++) if (arb_gnt[i]) cur_owner = i;
          last_src = cur_owner;
          for (int k = 0; k < BL; k++) begin
            b.idx  = cur_owner;
            b.data = data_mem[cur_owner][(sent_cnt[cur_owner] + k) % MEM];
            b.last = (k == BL - 1);
            exp_q.push_back(b);
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_arb_req"}, arb_req, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_src_ready"}, src_ready, 0);
    check({tag, "_m_last"}, m_last, 0);
    check({tag, "_m_src"}, m_src, 0);
    check({tag, "_busy"}, busy, 0);
`ifdef ARB_BURST_XFER_GNT_CHECK_EN
    check({tag, "_gnt_err"}, gnt_err, 0);
`endif
  endtask

  initial begin
    bit found;
    for (int i = 0; i < N; i++) begin
      sent_cnt[i] = 0;
      for (int n = 0; n < MEM; n++) data_mem[i][n] = 8'($urandom_range(255));
    end
    for (int n = 0; n < 4; n++) data_mem[0][n] = 8'(8'h10 + n);

    // Reset with requesters already asserting: every output must stay low.
    src_valid = '1;
    #3;
    check_all_zero("reset");
    repeat (2) drive_cycle();
    rst_n = 1'b1;

    // Single requester, one burst of 0x10..0x13, then back in IDLE.
    valid_mask = 4'b0001;
    repeat (12) drive_cycle();

    // All requesters valid: round-robin rotation across bursts.
    valid_mask = 4'b1111;
    repeat (30) drive_cycle();

    // Sink backpressure.
    p_ready = 50;
    repeat (60) drive_cycle();

    // Owner stalls (random valid drops) with other requesters active.
    p_ready = 100;
    p_valid = 60;
    repeat (60) drive_cycle();

    // Multi-hot grant in IDLE, then a stale grant for a non-requesting bit.
    p_valid      = 100;
    valid_mask   = 4'b0011;
    force_gnt_en = 1'b1;
    force_gnt    = 4'b0011;
    repeat (4) drive_cycle();
    force_gnt    = 4'b0100;
    repeat (4) drive_cycle();
    force_gnt_en = 1'b0;
    valid_mask   = 4'b1111;

    // Random grants including illegal ones.
    p_valid    = 70;
    p_ready    = 70;
    p_rand_gnt = 40;
    repeat (200) drive_cycle();
    p_rand_gnt = 0;

    // Reset in the middle of a burst.
    p_valid = 100;
    p_ready = 100;
    found   = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      drive_cycle();
      found = (cur_owner >= 0) && (exp_q.size() > 0) && (exp_q.size() < BL);
    end
    check("midburst_wait", found, 1);
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (2) drive_cycle();
    rst_n = 1'b1;

    // Long mixed random run.
    p_valid    = 80;
    p_ready    = 70;
    p_rand_gnt = 10;
    repeat (1500) drive_cycle();

    // Drain any burst in flight, bounded.
    p_valid    = 100;
    p_ready    = 100;
    p_rand_gnt = 0;
    for (int c = 0; c < 100 && !(exp_q.size() == 0 && cur_owner < 0); c++) drive_cycle();
    check("drain", exp_q.size(), 0);
    repeat (2) drive_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
